// File: rtl/pipe_reg_chain_if.sv
// ============================================================
// pipe_reg_chain_if : valid/ready/data handshake bundle
// Revision: 1.0
// ============================================================
`default_nettype none

interface pipe_reg_chain_if #(
   parameter int WIDTH = 32
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
// ============================================================
// pipe_reg_chain : elastic register chain with bubble collapsing,
//   stall, flush and an optional registered-ready input skid.
// Revision: 1.0
// ============================================================
`default_nettype none

module pipe_reg_chain #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 2,
   parameter int REG_READY = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         flush,
   pipe_reg_chain_if.slave              up,
   pipe_reg_chain_if.master             dn,
   output logic [$clog2(DEPTH+2)-1:0]   count
);

   localparam int c_cnt_w = $clog2(DEPTH + 2);

   logic [DEPTH-1:0] r_v;
   logic [DEPTH-1:0] w_v_nxt;
   logic [DEPTH-1:0] w_adv;
   logic [WIDTH-1:0] r_d     [DEPTH];
   logic [WIDTH-1:0] w_d_nxt [DEPTH];
   logic             r_sv;
   logic             w_sv_nxt;
   logic [WIDTH-1:0] r_sd;
   logic [WIDTH-1:0] w_sd_nxt;
   logic [c_cnt_w-1:0] r_count;
   logic [c_cnt_w-1:0] w_count_nxt;
   logic             w_f0;
   logic             w_in_xfer;

   // A stage advances when the slot ahead is empty or is itself advancing.
   always_comb begin
      logic [DEPTH-1:0] adv;
      adv = '0;
      adv[DEPTH-1] = r_v[DEPTH-1] & dn.ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         adv[i] = r_v[i] & (~r_v[i+1] | adv[i+1]);
      end
      w_adv = adv;
   end

   assign w_f0 = ~r_v[0] | w_adv[0];

   generate
      if (REG_READY != 0) begin : g_skid_ready
         assign up.ready = ~r_sv;
      end else begin : g_comb_ready
         assign up.ready = w_f0 & ~stall & ~flush & reset;
      end
   endgenerate

   assign w_in_xfer = up.valid & up.ready;

   always_comb begin
      w_v_nxt  = r_v;
      w_d_nxt  = r_d;
      w_sv_nxt = r_sv;
      w_sd_nxt = r_sd;
      if (flush) begin
         w_v_nxt  = '0;
         w_sv_nxt = 1'b0;
      end else if (stall) begin
         // A handshake already promised by the registered ready must not be lost.
         if (REG_READY != 0 && w_in_xfer) begin
            w_sv_nxt = 1'b1;
            w_sd_nxt = up.data;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (w_adv[i-1]) begin
               w_v_nxt[i] = 1'b1;
               w_d_nxt[i] = r_d[i-1];
            end else if (w_adv[i]) begin
               w_v_nxt[i] = 1'b0;
            end
         end
         if (REG_READY != 0 && r_sv && w_f0) begin
            w_v_nxt[0] = 1'b1;
            w_d_nxt[0] = r_sd;
            w_sv_nxt   = 1'b0;
         end else if (w_in_xfer && w_f0) begin
            w_v_nxt[0] = 1'b1;
            w_d_nxt[0] = up.data;
         end else if (REG_READY != 0 && w_in_xfer) begin
            w_sv_nxt = 1'b1;
            w_sd_nxt = up.data;
         end else if (w_adv[0]) begin
            w_v_nxt[0] = 1'b0;
         end
      end

      w_count_nxt = c_cnt_w'(w_sv_nxt);
      for (int i = 0; i < DEPTH; i++) begin
         w_count_nxt = w_count_nxt + c_cnt_w'(w_v_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v     <= '0;
         r_sv    <= 1'b0;
         r_sd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_d[i] <= '0;
         end
      end else begin
         r_v     <= w_v_nxt;
         r_sv    <= w_sv_nxt;
         r_sd    <= w_sd_nxt;
         r_count <= w_count_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            r_d[i] <= w_d_nxt[i];
         end
      end
   end

   assign dn.valid = r_v[DEPTH-1] & ~stall & ~flush;
   assign dn.data  = r_d[DEPTH-1];
   assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
// ============================================================
// tb_pipe_reg_chain : three chain variants driven in lockstep and
//   compared every cycle against a slot-shifting reference model.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_pipe_reg_chain;

   logic       clk = 1'b0;
   logic       reset, stall, flush, in_valid, out_ready;
   logic [7:0] in_data;
   logic [2:0] cnt_0, cnt_1, cnt_2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pipe_reg_chain_if #(.WIDTH(8)) up_0 ();
   pipe_reg_chain_if #(.WIDTH(8)) dn_0 ();
   pipe_reg_chain_if #(.WIDTH(8)) up_1 ();
   pipe_reg_chain_if #(.WIDTH(8)) dn_1 ();
   pipe_reg_chain_if #(.WIDTH(8)) up_2 ();
   pipe_reg_chain_if #(.WIDTH(8)) dn_2 ();

   assign up_0.valid = in_valid;  assign up_0.data = in_data;  assign dn_0.ready = out_ready;
   assign up_1.valid = in_valid;  assign up_1.data = in_data;  assign dn_1.ready = out_ready;
   assign up_2.valid = in_valid;  assign up_2.data = in_data;  assign dn_2.ready = out_ready;

   pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .REG_READY(0)) u_chain_0 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .up(up_0), .dn(dn_0), .count(cnt_0));
   pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .REG_READY(1)) u_chain_1 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .up(up_1), .dn(dn_1), .count(cnt_1));
   pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .REG_READY(0)) u_chain_2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .up(up_2), .dn(dn_2), .count(cnt_2));

   logic       obs_rdy [3];
   logic       obs_vld [3];
   logic [7:0] obs_dat [3];
   logic [2:0] obs_cnt [3];
   assign obs_rdy[0] = up_0.ready; assign obs_vld[0] = dn_0.valid; assign obs_dat[0] = dn_0.data; assign obs_cnt[0] = cnt_0;
   assign obs_rdy[1] = up_1.ready; assign obs_vld[1] = dn_1.valid; assign obs_dat[1] = dn_1.data; assign obs_cnt[1] = cnt_1;
   assign obs_rdy[2] = up_2.ready; assign obs_vld[2] = dn_2.valid; assign obs_dat[2] = dn_2.data; assign obs_cnt[2] = cnt_2;

   // Reference model: slots of each chain plus a skid entry.
   int         m_depth [3] = '{3, 3, 4};
   bit         m_rr    [3] = '{1'b0, 1'b1, 1'b0};
   bit         m_v     [3][8];
   logic [7:0] m_d     [3][8];
   bit         m_sv    [3];
   logic [7:0] m_sd    [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear(input int k);
      for (int j = 0; j < 8; j++) begin
         m_v[k][j] = 1'b0;
         m_d[k][j] = 8'h00;
      end
      m_sv[k] = 1'b0;
      m_sd[k] = 8'h00;
   endtask

   // Compare all outputs just after the input change, then advance the model.
   task automatic tick();
      #2;
      for (int k = 0; k < 3; k++) begin
         int         dep;
         int         cnt;
         bit         nv [8];
         logic [7:0] nd [8];
         bit         f0, rdy, vld, xfer;
         dep = m_depth[k];
         if (!reset) model_clear(k);
         cnt = int'(m_sv[k]);
         for (int j = 0; j < 8; j++) begin
            nv[j] = m_v[k][j];
            nd[j] = m_d[k][j];
            if (j < dep) cnt += int'(m_v[k][j]);
         end
         if (nv[dep-1] && out_ready) nv[dep-1] = 1'b0;
         for (int j = dep - 2; j >= 0; j--) begin
            if (nv[j] && !nv[j+1]) begin
               nv[j+1] = 1'b1;
               nd[j+1] = nd[j];
               nv[j]   = 1'b0;
            end
         end
         f0  = !nv[0];
         rdy = m_rr[k] ? !m_sv[k] : (f0 && !stall && !flush && reset);
         vld = m_v[k][dep-1] && !stall && !flush;
         check($sformatf("u%0d.in_ready", k), 32'(obs_rdy[k]), 32'(rdy));
         check($sformatf("u%0d.out_valid", k), 32'(obs_vld[k]), 32'(vld));
         check($sformatf("u%0d.out_data", k), 32'(obs_dat[k]), 32'(m_d[k][dep-1]));
         check($sformatf("u%0d.count", k), 32'(obs_cnt[k]), 32'(cnt));
         xfer = in_valid && rdy;
         if (!reset) begin
            model_clear(k);
         end else if (flush) begin
            for (int j = 0; j < 8; j++) m_v[k][j] = 1'b0;
            m_sv[k] = 1'b0;
         end else if (stall) begin
            if (xfer && m_rr[k]) begin
               m_sv[k] = 1'b1;
               m_sd[k] = in_data;
            end
         end else begin
            if (m_rr[k] && m_sv[k] && f0) begin
               nv[0]   = 1'b1;
               nd[0]   = m_sd[k];
               m_sv[k] = 1'b0;
            end else if (xfer && f0) begin
               nv[0] = 1'b1;
               nd[0] = in_data;
            end else if (xfer) begin
               m_sv[k] = 1'b1;
               m_sd[k] = in_data;
            end
            for (int j = 0; j < 8; j++) begin
               m_v[k][j] = nv[j];
               m_d[k][j] = nd[j];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit iv, input logic [7:0] id, input bit ordy, input bit st, input bit fl);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
      tick();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) model_clear(k);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
      @(negedge clk);
      tick();
      tick();
      reset = 1'b1;

      // back-to-back stream
      for (int i = 1; i <= 10; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)   drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // back-pressure fills the chain, then drains
      for (int i = 0; i < 6; i++)   drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      check("bp_count_rr1", 32'(cnt_1), 32'd4);
      check("bp_ready_rr1", 32'(up_1.ready), 32'd0);
      for (int i = 0; i < 8; i++)   drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // bubble collapse
      drive(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)   drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("bubble_count", 32'(cnt_2), 32'd2);
      check("bubble_head", 32'(dn_2.data), 32'hA0);
      for (int i = 0; i < 8; i++)   drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // flush discards contents and the same-cycle input
      for (int i = 0; i < 3; i++)   drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
      check("flush_count0", 32'(cnt_0), 32'd0);
      check("flush_count1", 32'(cnt_1), 32'd0);
      check("flush_count2", 32'(cnt_2), 32'd0);
      for (int i = 0; i < 6; i++)   drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // stall mid-stream
      for (int i = 0; i < 12; i++)  drive(1'b1, 8'(8'h40 + i), 1'b1, (i >= 4 && i < 9), 1'b0);
      for (int i = 0; i < 6; i++)   drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // asynchronous reset with a loaded chain
      for (int i = 0; i < 3; i++)   drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check("areset_count", 32'(cnt_0), 32'd0);
      check("areset_valid", 32'(dn_1.valid), 32'd0);
      tick();
      reset = 1'b1;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) != 0);
         drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
      end
      reset = 1'b1;
      for (int i = 0; i < 8; i++)   drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised elastic pipeline-register chain for the Pipeline datapath. It moves WIDTH-bit payloads through DEPTH register stages under a valid/ready handshake, with bubble collapsing, global stall, global flush, and an optional input skid buffer that registers `in_ready`. It generalises the fixed inter-stage registers between Pipeline stages, adding depth, width, back-pressure and a registered-ready mode.

## Interface
- WIDTH, 32: payload width in bits, ≥1.
- DEPTH, 2: number of register stages, 1..8.
- REG_READY, 0: 1 adds a one-entry input skid buffer so `in_ready` is a flop output.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- stall  in  1  freezes all state; no transfers in or out.
- flush  in  1  invalidates every stage and the skid entry; has priority over stall.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  chain accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  last stage holds a payload.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  last-stage payload.
- count  out  $clog2(DEPTH+2)  occupied entries, stages plus skid.

## Operation
- State: `v[i]` and `d[i]` for i=0..DEPTH-1. With REG_READY=1, also `sv` and `sd`.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- `out_valid = v[DEPTH-1] & ~stall & ~flush`. `out_data = d[DEPTH-1]`, even when invalid.
- Stage advance, bubble collapsing:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i < DEPTH-1: adv[i] = v[i] & (~v[i+1] | adv[i+1]).
  - Stage i+1 loads d[i] when adv[i]. It clears when adv[i+1] & ~adv[i].
- Stage 0 free: `f0 = ~v[0] | adv[0]`.
- REG_READY=0:
  - `in_ready = f0 & ~stall & ~flush`. This is a combinational path from `out_ready`.
  - Stage 0 loads `in_data` on an input transfer.
- REG_READY=1:
  - `in_ready = ~sv`, registered, independent of stall/flush inputs.
  - Input transfer while stall=0, flush=0 and f0=1: payload goes straight to stage 0, bypassing the skid (no added latency).
  - Input transfer while stall or flush or ~f0: payload goes to the skid (sv←1), except under flush, where it is dropped.
  - sv=1 with f0=1 and not stalled: stage 0 loads sd and sv←0.
- stall=1, flush=0: all state holds and no handshake completes. With REG_READY=1, an in-flight input transfer is still captured into an empty skid.
- flush=1: next state is v[*]=0 and sv=0. Any same-cycle input is discarded. `count` reads 0 next cycle.
- `count` equals the number of set `v` bits plus `sv`, registered with state.
- Reset (reset=0): v[*]=0, sv=0, d/sd=0, count=0.
  - Output values during reset: out_valid=0, out_data=0. in_ready=0 when REG_READY=0; in_ready=1 when REG_READY=1.
  - Reset asserted mid-transfer discards everything immediately, asynchronously.

## Timing
- Latency: an input accepted at edge t into an empty chain shows out_valid=1 after edge t+DEPTH-1, i.e. visible DEPTH cycles after the in_valid cycle.
- Throughput: 1 payload/cycle when out_ready=1 and stall=0, for any DEPTH.
- Back-pressure: out_ready=0 fills the chain within DEPTH cycles. Once full:
  - REG_READY=0: in_ready drops in the same cycle.
  - REG_READY=1: one more payload lands in the skid, then in_ready drops on the following cycle.
- Bubbles: a gap in the input stream collapses as soon as the stage ahead stalls.
- Simultaneous events, highest priority first: reset > flush > stall > normal.
- Simultaneous in/out transfer at full occupancy keeps `count` unchanged.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 → out_valid=0, count=0, out_data=0. in_ready=0 (REG_READY=0) or in_ready=1 (REG_READY=1).
- Streaming (DEPTH=3, WIDTH=8): drive 0x01..0x0A back-to-back with out_ready=1 → out_data 0x01..0x0A in order, first one 3 cycles after input, no gaps, count=3 in steady state.
- Back-pressure (DEPTH=3, REG_READY=1):
  - out_ready=0 while driving 0x10, 0x11, … → exactly 4 accepted, in_ready=0, count=4.
  - Then release out_ready → outputs 0x10..0x13 in order, no loss or duplication.
- Bubble collapse (DEPTH=4): inputs 0xA0, gap, 0xA1 with out_ready=0 for 6 cycles → v[3]=v[2]=1 holding 0xA0, 0xA1, count=2.
- Flush: fill with 3 items, then assert flush with in_valid=1, in_data=0xFF → next cycle count=0, out_valid=0, and 0xFF never emerges.
- Stall: stall=1 for 5 cycles mid-stream with out_ready=1 → out_valid=0, state unchanged. Stream resumes in order on release, with no item dropped.
